// File: rtl/huff_decoder.sv
// Three-entry prefix-code (Huffman) decoder: loads {char, mask, value} entries, then decodes a serial MSB-first bit stream.
// Optional macro HUFF_DEC_ERR_EN: a 3-bit code with no match becomes a sticky error instead of being silently dropped.
module huff_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] io_in,
  output logic [11:0] io_out
);

  typedef enum logic [1:0] {LOAD_CHAR, LOAD_CODE, DECODE, ERR} state_t;

  state_t      state, state_nx;
  logic [7:0]  tbl_char [3];
  logic [2:0]  tbl_mask [3];
  logic [2:0]  tbl_val  [3];
  logic [1:0]  idx;
  logic [2:0]  acc;
  logic [1:0]  len;
  logic [7:0]  out_char;
  logic        out_valid;
  logic        out_err;

  logic        soft_clr, word_vld, bit_vld, bit_val, bit_take;
  logic [2:0]  acc_nx;
  logic [1:0]  len_nx;
  logic        hit;
  logic [1:0]  hit_idx;

  assign word_vld = io_in[8];
  assign bit_vld  = io_in[9];
  assign bit_val  = io_in[10];
  assign soft_clr = io_in[11];

  function automatic logic [1:0] popcnt3(input logic [2:0] m);
    return 2'(m[0]) + 2'(m[1]) + 2'(m[2]);
  endfunction

  // Match is evaluated on the post-shift accumulator so a code completes on its last bit's edge.
  always_comb begin
    bit_take = (state == DECODE) && bit_vld;
    acc_nx   = {acc[1:0], bit_val};
    len_nx   = len + 2'd1;
    hit      = 1'b0;
    hit_idx  = 2'd0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (!hit && len_nx == popcnt3(tbl_mask[i]) && (acc_nx & tbl_mask[i]) == tbl_val[i]) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
    end
  end

  always_comb begin
    state_nx = state;
    if (soft_clr) begin
      state_nx = LOAD_CHAR;
    end else begin
      case (state)
        LOAD_CHAR: if (word_vld) state_nx = LOAD_CODE;
        LOAD_CODE: if (word_vld) state_nx = (idx == 2'd2) ? DECODE : LOAD_CHAR;
`ifdef HUFF_DEC_ERR_EN
        DECODE:    if (bit_take && !hit && len_nx == 2'd3) state_nx = ERR;
`endif
        default:   state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD_CHAR;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 3; i++) begin
        tbl_char[i] <= '0;
        tbl_mask[i] <= '0;
        tbl_val[i]  <= '0;
      end
      idx       <= '0;
      acc       <= '0;
      len       <= '0;
      out_char  <= '0;
      out_valid <= 1'b0;
    end else if (soft_clr) begin
      for (int unsigned i = 0; i < 3; i++) begin
        tbl_char[i] <= '0;
        tbl_mask[i] <= '0;
        tbl_val[i]  <= '0;
      end
      idx       <= '0;
      acc       <= '0;
      len       <= '0;
      out_char  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        LOAD_CHAR: if (word_vld) tbl_char[idx] <= io_in[7:0];
        LOAD_CODE: begin
          if (word_vld) begin
            tbl_mask[idx] <= io_in[5:3];
            tbl_val[idx]  <= io_in[2:0];
            if (idx != 2'd2) idx <= idx + 2'd1;
          end
        end
        DECODE: begin
          if (bit_take) begin
            if (hit) begin
              out_char  <= tbl_char[hit_idx];
              out_valid <= 1'b1;
              acc       <= '0;
              len       <= '0;
            end else if (len_nx == 2'd3) begin
              acc <= '0;
              len <= '0;
            end else begin
              acc <= acc_nx;
              len <= len_nx;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef HUFF_DEC_ERR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   out_err <= 1'b0;
    else if (soft_clr)                            out_err <= 1'b0;
    else if (bit_take && !hit && len_nx == 2'd3)  out_err <= 1'b1;
  end
`else
  assign out_err = 1'b0;
`endif

  assign io_out = {(len != 2'd0), (state == DECODE || state == ERR), out_err, out_valid, out_char};

endmodule

// File: tb/tb_huff_decoder.sv
// Bench for huff_decoder: fixed vectors for the documented scenarios plus randomized traffic against a word/bit-level model.
module tb_huff_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] io_in;
  logic [11:0] io_out;

  int unsigned tests = 0;
  int unsigned fails = 0;

  huff_decoder dut (
    .clk    (clk),
    .reset  (reset),
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] in;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Reference model: words counted 0..6, pending code kept as an integer plus bit count.
  logic [7:0] m_chr [3];
  logic [2:0] m_msk [3];
  logic [2:0] m_val [3];
  int         m_words;
  int         m_code;
  int         m_clen;
  logic       m_err;
  logic       m_vld;
  logic [7:0] m_char;

  function automatic logic [11:0] model_out();
    return {(m_clen != 0), (m_words == 6), m_err, m_vld, m_char};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_chr[i] = 8'h00;
      m_msk[i] = 3'd0;
      m_val[i] = 3'd0;
    end
    m_words = 0;
    m_code  = 0;
    m_clen  = 0;
    m_err   = 1'b0;
    m_vld   = 1'b0;
    m_char  = 8'h00;
  endtask

  task automatic model_edge(input logic [11:0] in);
    int hit;
    m_vld = 1'b0;
    if (in[11]) begin
      model_clear();
      return;
    end
    if (m_words < 6) begin
      if (in[8]) begin
        if (m_words % 2 == 0) m_chr[m_words / 2] = in[7:0];
        else begin
          m_msk[m_words / 2] = in[5:3];
          m_val[m_words / 2] = in[2:0];
        end
        m_words++;
      end
    end else if (!m_err && in[9]) begin
      m_code = m_code * 2 + int'(in[10]);
      m_clen++;
      hit = -1;
      for (int i = 0; i < 3; i++)
        if (hit < 0 && m_clen == $countones(m_msk[i]) && (m_code & int'(m_msk[i])) == int'(m_val[i]))
          hit = i;
      if (hit >= 0) begin
        m_char = m_chr[hit];
        m_vld  = 1'b1;
        m_code = 0;
        m_clen = 0;
      end else if (m_clen == 3) begin
`ifdef HUFF_DEC_ERR_EN
        m_err = 1'b1;
`endif
        m_code = 0;
        m_clen = 0;
      end
    end
  endtask

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: io_out=%h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input string nm, input logic [11:0] in);
    @(negedge clk);
    io_in = in;
    @(posedge clk);
    model_edge(in);
    #1;
    check(nm, io_out, model_out());
  endtask

  task automatic run_vectors(input string nm);
    foreach (vecs[k]) begin
      @(negedge clk);
      io_in = vecs[k].in;
      @(posedge clk);
      model_edge(vecs[k].in);
      #1;
      check($sformatf("%s[%0d]", nm, k), io_out, vecs[k].exp);
    end
  endtask

  function automatic vec_t mk(input logic [11:0] in, input logic [11:0] exp);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    return v;
  endfunction

  initial begin
    vecs.push_back(mk(12'h161, 12'h000));
    vecs.push_back(mk(12'h109, 12'h000));
    vecs.push_back(mk(12'h16E, 12'h000));
    vecs.push_back(mk(12'h118, 12'h000));
    vecs.push_back(mk(12'h16D, 12'h000));
    vecs.push_back(mk(12'h119, 12'h400));
    vecs.push_back(mk(12'h600, 12'h561));
    vecs.push_back(mk(12'h200, 12'hC61));
    vecs.push_back(mk(12'h200, 12'h56E));
    vecs.push_back(mk(12'h200, 12'hC6E));
    vecs.push_back(mk(12'h600, 12'h56D));
    vecs.push_back(mk(12'h000, 12'h46D));

    model_clear();
    reset = 1'b0;
    io_in = 12'h000;
    #1;
    check("reset_state", io_out, 12'h000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", io_out, 12'h000);
    @(negedge clk);
    reset = 1'b1;

    run_vectors("load_decode");

    // Soft clear beats a same-edge code bit; partial code is discarded.
    @(negedge clk);
    io_in = 12'h200;
    @(posedge clk);
    model_edge(12'h200);
    #1;
    check("partial_bit", io_out, 12'hC6D);
    @(negedge clk);
    io_in = 12'hE00;
    @(posedge clk);
    model_edge(12'hE00);
    #1;
    check("soft_clear", io_out, 12'h000);
    @(negedge clk);
    io_in = 12'h000;
    @(posedge clk);
    #1;
    check("soft_clear_hold", io_out, 12'h000);

    // Reset in the middle of a table load.
    for (int k = 0; k < 3; k++) drive("midload", vecs[k].in);
    @(negedge clk);
    io_in = 12'h000;
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    check("async_reset", io_out, 12'h000);
    @(negedge clk);
    reset = 1'b1;
    run_vectors("reload_decode");

    // Length-3 miss: sticky error with the macro, silent drop without it.
    drive("errtbl_clr", 12'h800);
    drive("errtbl_w0", 12'h141);
    drive("errtbl_w1", 12'h138);
    drive("errtbl_w2", 12'h142);
    drive("errtbl_w3", 12'h139);
    drive("errtbl_w4", 12'h143);
    drive("errtbl_w5", 12'h13A);
    drive("miss_b0", 12'h600);
    drive("miss_b1", 12'h600);
    drive("miss_b2", 12'h600);
`ifdef HUFF_DEC_ERR_EN
    check("err_flag", {11'd0, io_out[9]}, 12'h001);
`else
    check("err_flag", {11'd0, io_out[9]}, 12'h000);
`endif
    drive("after_b0", 12'h200);
    drive("after_b1", 12'h200);
    drive("after_b2", 12'h200);
`ifdef HUFF_DEC_ERR_EN
    check("err_no_pulse", io_out & 12'h3FF, 12'h200);
`else
    check("entry0_decode", io_out, 12'h541);
`endif

    // Randomized traffic, including random tables and occasional soft clears.
    drive("rand_clr", 12'h800);
    for (int n = 0; n < 600; n++) begin
      logic [11:0] r;
      r        = 12'($urandom);
      r[11]    = ($urandom_range(0, 59) == 0);
      drive("random", r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/huff_decoder.md
HUFF_DECODER -- requirements
Module: huff_decoder

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-low; asserting (0) clears all state immediately, release synchronous to clk.
REQ-003 io_in  input  12  [7:0] table word, [8] table word valid, [9] code bit valid, [10] code bit value, [11] soft clear.
REQ-004 io_out  output  12  [7:0] decoded char, [8] char valid, [9] error, [10] table loaded, [11] busy (partial code held).
REQ-005 Table word format: first word of each pair is an ASCII char [7:0]; second word has mask [5:3] and code value [2:0], with [7:6] ignored.

Function
REQ-006 The block SHALL hold a 3-entry table {char[7:0], mask[2:0], value[2:0]}, filled in order entry0..entry2.
REQ-007 FSM states SHALL be LOAD_CHAR, LOAD_CODE, DECODE, ERR; the reset state is LOAD_CHAR.
REQ-008 LOAD_CHAR: on io_in[8]=1, store io_in[7:0] as char[idx] -> LOAD_CODE.
REQ-009 LOAD_CODE: on io_in[8]=1, store mask/value[idx]; if idx=2 -> DECODE with io_out[10]=1, else idx+1 -> LOAD_CHAR.
REQ-010 io_in[9] SHALL be ignored outside DECODE; io_in[8] SHALL be ignored in DECODE and ERR.
REQ-011 Code bits SHALL arrive MSB-first; in DECODE, each io_in[9]=1 cycle shifts io_in[10] into a 3-bit accumulator (acc={acc[1:0],bit}) and increments length (0..3).
REQ-012 A match is declared when, after the shift, length = popcount(mask[i]) and (acc & mask[i]) = value[i]; the lowest index wins if several entries match.
REQ-013 On a match, io_out[7:0]=char[i] and io_out[8]=1 SHALL be registered on the sampling edge (one-cycle pulse), and acc/length clear on the same edge.
REQ-014 io_out[8] SHALL be 0 in every cycle that does not follow a match; io_out[7:0] holds the last decoded char.
REQ-015 io_out[11] SHALL equal (length != 0).
REQ-016 Back-to-back bits on consecutive cycles SHALL be accepted with no stall; the decoder's throughput is one bit per cycle.
REQ-017 io_in[11]=1 SHALL take priority over all other inputs on the same edge: the table clears, idx/acc/length clear, io_out clears, and the FSM goes to LOAD_CHAR.

Reset
REQ-018 While reset=0, the FSM SHALL be in LOAD_CHAR, with idx=0, acc=0, length=0, table=0, and io_out=12'h000.
REQ-019 A reset asserted mid-load or mid-code SHALL discard the partial table and partial code; no char valid is produced.

Configuration
REQ-020 Macro HUFF_DEC_ERR_EN: when defined, reaching length=3 with no match SHALL enter ERR, set io_out[9]=1 (sticky), and ignore code bits until soft clear or reset.
REQ-021 Without HUFF_DEC_ERR_EN, a length-3 miss SHALL silently clear acc/length, stay in DECODE, and tie io_out[9] to 0.

Verification
REQ-022 Load table a/{mask 001, value 001}, n/{011, 000}, m/{011, 001} (words 0x61, 0x09, 0x6E, 0x18, 0x6D, 0x19) -> io_out[10]=1 one cycle after the 6th word.
REQ-023 Bits 1,0,0,0,1 on consecutive cycles -> char pulses 0x61, 0x6E, 0x6D in that order, with io_out[11]=1 only between the bits of 2-bit codes.
REQ-024 Issue bit 0, then soft clear together with bit value 1 on the next edge -> no char pulse, io_out=0, FSM in LOAD_CHAR.
REQ-025 With HUFF_DEC_ERR_EN and a table whose masks are all 111 and values 000/001/010, send bits 1,1,1 -> io_out[9]=1 stays set and further bits produce no pulse; without the macro, the same stimulus gives no error and the next bits 0,0,0 decode entry0.
REQ-026 Assert reset=0 after 3 table words, then release and reload the full table -> decoding matches REQ-023 exactly.
